// File: rtl/if_pkg.sv
// Shared types and defaults for the prefetching instruction-fetch stage.
package if_pkg;

    localparam int IF_ADDR_W = 32;
    localparam int IF_DATA_W = 32;

    localparam logic [31:0] DEF_RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] DEF_EXC_VECTOR = 32'h8000_0080;

    // Byte distance between consecutive instructions.
    localparam int PC_INC = 4;

    // One fetched instruction together with the address it came from.
    typedef struct packed {
        logic [IF_ADDR_W-1:0] pc;
        logic [IF_DATA_W-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/if_prefetch_if.sv
// Instruction-memory request/response bus seen by the fetch stage.
interface if_prefetch_if
    import if_pkg::*;
#(
    parameter int ADDR_W = IF_ADDR_W,
    parameter int DATA_W = IF_DATA_W
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic              imem_rvalid;
    logic [DATA_W-1:0] imem_rdata;

    // Fetch-stage side: issues requests, consumes in-order responses.
    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rvalid, imem_rdata
    );

    // Memory side.
    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rvalid, imem_rdata
    );
endinterface

// File: rtl/if_prefetch_fetch_queue.sv
// Small synchronous FIFO with optional flush; DEPTH must be a power of two.
module fetch_queue #(
    parameter int  DEPTH    = 4,
    parameter type T        = logic,
    parameter bit  FLUSH_EN = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  T                       push_data,
    input  logic                   pop,
    input  logic                   flush,
    output T                       head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int             AW       = $clog2(DEPTH);
    localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);

    T                mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            do_flush;
    logic            do_push;
    logic            do_pop;

    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign head     = mem[rd_ptr];
    assign do_flush = FLUSH_EN && flush;
    assign do_pop   = pop && !empty;
    // A push into a full queue is only taken when a pop frees the slot.
    assign do_push  = push && (!full || do_pop);

    // Pointer and occupancy bookkeeping; a flush empties the queue and wins over push/pop.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (do_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Entry storage.
    // NOTE: storage has no reset; the pointers and count alone decide which entries are meaningful.
    always_ff @(posedge clk) begin
        if (do_push && !do_flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/if_prefetch.sv
// Prefetching IF stage: keeps up to DEPTH instructions queued or in flight,
// decouples fetch from decode stalls and drops stale responses after redirects.
module if_prefetch
    import if_pkg::*;
#(
    parameter int                DEPTH      = 4,
    parameter int                ADDR_W     = IF_ADDR_W,
    parameter int                DATA_W     = IF_DATA_W,
    parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(DEF_RESET_PC),
    parameter logic [ADDR_W-1:0] EXC_VECTOR = ADDR_W'(DEF_EXC_VECTOR)
) (
    input  logic               clk,
    input  logic               rst_n,
    if_prefetch_if.master      imem,
    input  logic               br,
    input  logic [ADDR_W-1:0]  pc_branch,
    input  logic               except,
    input  logic               hold_if,
    output logic [ADDR_W-1:0]  pc_out,
    output logic [DATA_W-1:0]  inst_out,
    output logic               valid_out
);
    localparam int CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] inst;
    } entry_t;

    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] flight_pc;
    logic [CW-1:0]     count;
    logic [CW-1:0]     pend;
    logic [CW-1:0]     pend_next;
    logic [CW-1:0]     discard;
    logic [CW:0]       occupancy;
    entry_t            enq_entry;
    entry_t            head;
    logic              q_full, q_empty, f_full, f_empty;
    logic              accept, resp, drop, enq, pop_q, redirect;

    // Requests stop once queued plus outstanding instructions fill the queue.
    assign occupancy      = {1'b0, count} + {1'b0, pend};
    assign imem.imem_req  = (occupancy < (CW+1)'(DEPTH));
    assign imem.imem_addr = fetch_pc;

    assign accept    = imem.imem_req && imem.imem_ack;
    assign resp      = imem.imem_rvalid;
    assign drop      = resp && (discard != '0);
    assign enq       = resp && !drop;
    assign redirect  = except || br;
    assign pop_q     = !redirect && !hold_if && !q_empty;
    assign pend_next = pend + CW'(accept) - CW'(resp);
    assign enq_entry = '{pc: flight_pc, inst: imem.imem_rdata};

    // Fetched instructions awaiting decode; flushed on every redirect.
    fetch_queue #(.DEPTH(DEPTH), .T(entry_t), .FLUSH_EN(1'b1)) u_entry_q (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (enq),
        .push_data (enq_entry),
        .pop       (pop_q),
        .flush     (redirect),
        .head      (head),
        .count     (count),
        .full      (q_full),
        .empty     (q_empty)
    );

    // Addresses of outstanding requests; its occupancy is the pending count.
    // Never flushed, so each response still pairs with its own request PC.
    fetch_queue #(.DEPTH(DEPTH), .T(logic [ADDR_W-1:0]), .FLUSH_EN(1'b0)) u_flight_q (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (accept),
        .push_data (fetch_pc),
        .pop       (resp),
        .flush     (1'b0),
        .head      (flight_pc),
        .count     (pend),
        .full      (f_full),
        .empty     (f_empty)
    );

    // Fetch PC: exception beats branch, otherwise advance on each accepted request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        fetch_pc <= RESET_PC;
        else if (except)   fetch_pc <= EXC_VECTOR;
        else if (br)       fetch_pc <= pc_branch;
        else if (accept)   fetch_pc <= fetch_pc + ADDR_W'(PC_INC);
    end

    // Stale-response counter: on redirect every request still outstanding after
    // this edge (including one accepted now) belongs to the old stream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        discard <= '0;
        else if (redirect) discard <= pend_next;
        else if (drop)     discard <= discard - 1'b1;
    end

    // Output register to ID: bubble on redirect, frozen while decode stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_out    <= '0;
            inst_out  <= '0;
            valid_out <= 1'b0;
        end else if (redirect) begin
            valid_out <= 1'b0;
        end else if (!hold_if) begin
            if (!q_empty) begin
                pc_out    <= head.pc;
                inst_out  <= head.inst;
                valid_out <= 1'b1;
            end else begin
                valid_out <= 1'b0;
            end
        end
    end

    a_entry_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(enq && q_full && !pop_q && !redirect));
    a_flight_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(accept && f_full && !resp));
    a_no_orphan_response: assert property (@(posedge clk) disable iff (!rst_n)
        !(resp && f_empty));
    a_discard_bound: assert property (@(posedge clk) disable iff (!rst_n)
        discard <= pend);

endmodule

// File: tb/tb_if_prefetch.sv
// Directed bench for if_prefetch with an in-order variable-latency memory model.
module tb_if_prefetch;
    import if_pkg::*;

    typedef struct {
        logic [31:0] addr;
        int          ready;
    } mreq_t;

    logic        clk;
    logic        rst_n;
    logic        br;
    logic        except;
    logic        hold_if;
    logic [31:0] pc_branch;
    logic [31:0] pc_out, inst_out;
    logic        valid_out;
    logic [31:0] w_pc_out, w_inst_out;
    logic        w_valid_out;

    int    checks;
    int    errors;
    int    cyc;
    int    acc_cnt;
    int    lat;
    int    acc0;
    mreq_t mq[$];

    if_prefetch_if #(.ADDR_W(32), .DATA_W(32)) imem_bus ();
    if_prefetch_if #(.ADDR_W(32), .DATA_W(32)) wrap_bus ();

    if_prefetch #(
        .DEPTH(4), .ADDR_W(32), .DATA_W(32),
        .RESET_PC(32'h0000_0000), .EXC_VECTOR(32'h8000_0080)
    ) dut (
        .clk(clk), .rst_n(rst_n), .imem(imem_bus),
        .br(br), .pc_branch(pc_branch), .except(except), .hold_if(hold_if),
        .pc_out(pc_out), .inst_out(inst_out), .valid_out(valid_out)
    );

    // Second instance only exercises address wrap-around near the top of memory.
    if_prefetch #(
        .DEPTH(4), .ADDR_W(32), .DATA_W(32),
        .RESET_PC(32'hFFFF_FFF8), .EXC_VECTOR(32'h8000_0080)
    ) dut_wrap (
        .clk(clk), .rst_n(rst_n), .imem(wrap_bus),
        .br(1'b0), .pc_branch(32'h0), .except(1'b0), .hold_if(1'b0),
        .pc_out(w_pc_out), .inst_out(w_inst_out), .valid_out(w_valid_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    // Memory bookkeeping at the active edge: retire the response, record the accept.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
        end else begin
            if (imem_bus.imem_rvalid && mq.size() > 0) mq.delete(0);
            if (imem_bus.imem_req && imem_bus.imem_ack) begin
                mq.push_back('{addr: imem_bus.imem_addr, ready: cyc + lat});
                acc_cnt <= acc_cnt + 1;
            end
            cyc <= cyc + 1;
        end
    end

    // Responses are presented mid-cycle, oldest request first, once its latency has elapsed.
    always @(negedge clk) begin
        if (rst_n && mq.size() > 0 && mq[0].ready <= cyc) begin
            imem_bus.imem_rvalid <= 1'b1;
            imem_bus.imem_rdata  <= inst_of(mq[0].addr);
        end else begin
            imem_bus.imem_rvalid <= 1'b0;
            imem_bus.imem_rdata  <= '0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [31:0] pc);
        fetch_entry_t e;
        e.pc   = pc;
        e.inst = inst_of(pc);
        check({tag, "_valid"}, {31'b0, valid_out}, 32'd1);
        check({tag, "_pc"},    pc_out,   e.pc);
        check({tag, "_inst"},  inst_out, e.inst);
    endtask

    task automatic wait_pend(input int n);
        int k;
        k = 0;
        while (mq.size() != n && k < 50) begin
            step();
            k++;
        end
        check($sformatf("pend_reached_%0d", n), 32'(mq.size()), 32'(n));
    endtask

    task automatic wait_valid(input string tag, input logic [31:0] pc);
        int k;
        k = 0;
        do begin
            step();
            k++;
        end while (!valid_out && k < 40);
        check_out(tag, pc);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        cyc     = 0;
        acc_cnt = 0;
        lat     = 1;
        rst_n   = 1'b0;
        br      = 1'b0;
        except  = 1'b0;
        hold_if = 1'b0;
        pc_branch = '0;
        imem_bus.imem_ack    = 1'b1;
        wrap_bus.imem_ack    = 1'b1;
        wrap_bus.imem_rvalid = 1'b0;
        wrap_bus.imem_rdata  = '0;

        // Reset values.
        repeat (2) @(posedge clk);
        #1;
        check("rst_addr",  imem_bus.imem_addr, 32'h0);
        check("rst_pc",    pc_out, 32'h0);
        check("rst_inst",  inst_out, 32'h0);
        check("rst_valid", {31'b0, valid_out}, 32'd0);
        rst_n = 1'b1;
        check("req_after_rst", {31'b0, imem_bus.imem_req}, 32'd1);
        check("wrap_addr0", wrap_bus.imem_addr, 32'hFFFF_FFF8);

        // Zero-wait memory: accept at E1, enqueue at E2, visible after E3.
        step();
        check("addr_e1",   imem_bus.imem_addr, 32'h4);
        check("valid_e1",  {31'b0, valid_out}, 32'd0);
        check("wrap_addr1", wrap_bus.imem_addr, 32'hFFFF_FFFC);
        step();
        check("valid_e2",  {31'b0, valid_out}, 32'd0);
        check("wrap_addr2", wrap_bus.imem_addr, 32'h0000_0000);
        step();
        check_out("lat_i0", 32'h0);
        step();
        check_out("lat_i1", 32'h4);
        step();
        check_out("lat_i2", 32'h8);
        check("wrap_no_valid", {31'b0, w_valid_out}, 32'd0);
        check("wrap_pc_out",   w_pc_out, 32'h0);
        check("wrap_inst_out", w_inst_out, 32'h0);

        // Branch with three requests outstanding on 3-cycle memory.
        lat = 3;
        wait_pend(3);
        br = 1'b1;
        pc_branch = 32'h100;
        step();
        br = 1'b0;
        check("br_addr",  imem_bus.imem_addr, 32'h100);
        check("br_valid", {31'b0, valid_out}, 32'd0);
        wait_valid("br_first", 32'h100);

        // Exception and branch together: exception wins.
        except = 1'b1;
        br = 1'b1;
        pc_branch = 32'h200;
        step();
        except = 1'b0;
        br = 1'b0;
        check("exc_addr",  imem_bus.imem_addr, 32'h8000_0080);
        check("exc_valid", {31'b0, valid_out}, 32'd0);
        wait_valid("exc_first",  32'h8000_0080);
        wait_valid("exc_second", 32'h8000_0084);

        // Asynchronous reset mid-burst with two requests outstanding.
        wait_pend(2);
        rst_n = 1'b0;
        #1;
        check("arst_addr",  imem_bus.imem_addr, 32'h0);
        check("arst_pc",    pc_out, 32'h0);
        check("arst_inst",  inst_out, 32'h0);
        check("arst_valid", {31'b0, valid_out}, 32'd0);
        hold_if = 1'b1;
        lat = 1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("restart_addr", imem_bus.imem_addr, 32'h0);

        // Decode stall from empty: four accepts fill the queue, then requests stop.
        acc0 = acc_cnt;
        repeat (10) step();
        check("hold_accepts", 32'(acc_cnt - acc0), 32'd4);
        check("hold_req",     {31'b0, imem_bus.imem_req}, 32'd0);
        check("hold_valid",   {31'b0, valid_out}, 32'd0);
        check("hold_pc",      pc_out, 32'h0);
        check("hold_addr",    imem_bus.imem_addr, 32'h10);

        // Release: queued instructions drain back to back, request reasserts after the first pop.
        hold_if = 1'b0;
        step();
        check_out("rel_i0", 32'h0);
        check("rel_req", {31'b0, imem_bus.imem_req}, 32'd1);
        step();
        check_out("rel_i1", 32'h4);
        step();
        check_out("rel_i2", 32'h8);
        step();
        check_out("rel_i3", 32'hC);
        step();
        check_out("rel_i4", 32'h10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
